dsc_mul_seq: RTL and testbench
==============================

// Module: dsc_mul_seq
// PURPOSE
//  Sequencer for the 3-input deterministic stochastic multiplier datapath (cascaded SNGs + stoch2bin counter).
//  Accepts one operand triple per valid/ready handshake and latches it onto the datapath inputs.
//  Clears the datapath, then enables it for exactly 2^(3*SNG_WIDTH) cycles and captures the product.
//  Returns the product on a valid/ready response port. Sits between the requesting engine and one multiplier.
// PARAMETERS
//  SNG_WIDTH   4                   operand width; datapath result width is 3*SNG_WIDTH
//  RUN_CYCLES  2**(3*SNG_WIDTH)    enabled cycles per multiply (4096 at default); derived, do not override
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst        in   1      synchronous reset, active-low
//  req_valid  in   1      operand triple valid
//  req_ready  out  1      sequencer can accept a request (IDLE only)
//  req_a/b/c  in   SNG_WIDTH  operands
//  mul_a/b/c  out  SNG_WIDTH  latched operands to datapath, stable for whole run
//  mul_clr    out  1      active-high datapath clear (SNG counters + result counter)
//  mul_en     out  1      datapath enable
//  mul_z      in   3*SNG_WIDTH  datapath result counter
//  mul_ov     in   1      datapath final-stage SNG overflow
//  rsp_valid  out  1      result valid
//  rsp_ready  in   1      consumer accepts result
//  rsp_z      out  3*SNG_WIDTH  product a*b*c
//  rsp_err    out  1      mul_ov never seen during RUN (datapath/sequence mismatch)
//  busy       out  1      high in any state but IDLE
// BEHAVIOUR
//  Reset (rst==0 at edge): state=IDLE; mul_a/b/c=0, mul_en=0, rsp_valid=0, rsp_z=0, rsp_err=0, busy=0,
//   run counter=0; mul_clr=1 while rst==0. Reset mid-run aborts without response.
//  FSM: IDLE -> CLEAR -> RUN -> CAPTURE -> RESP -> IDLE.
//   IDLE: req_ready=1. On req_valid&&req_ready at edge T0: latch operands, go CLEAR.
//   CLEAR (T0+1): mul_clr=1, mul_en=0, run counter=0, ov_seen=0.
//   RUN (T0+2 .. T0+1+RUN_CYCLES): mul_en=1; counter increments each cycle; ov_seen|=mul_ov;
//    leave on counter==RUN_CYCLES-1 (counter width 3*SNG_WIDTH, wraps to 0 exactly at exit).
//   CAPTURE (T0+2+RUN_CYCLES): mul_en=0; rsp_z<=mul_z, rsp_err<=~ov_seen.
//   RESP: rsp_valid=1, rsp_z/rsp_err stable until rsp_valid&&rsp_ready; then IDLE, rsp_valid=0.
//  Latency accept->rsp_valid: RUN_CYCLES+3 cycles (4099 at default). Throughput: one op per RUN_CYCLES+4 min.
//  req_ready=0 outside IDLE; no request is ever queued. A new request is accepted no earlier than
//   the cycle after the response handshake.
//  rsp_ready held high: RESP lasts exactly one cycle. rsp_ready low: stall indefinitely, datapath idle.
//  Product exact: max 15*15*15=3375 < 2^12, no saturation needed; width rule 3*SNG_WIDTH.
//  mul_a/b/c hold the last operands after completion (not cleared) until next accept or reset.
// CONFIGURATION
//  DSC_EARLY_TERM_EN defined: in IDLE, accept with any operand==0 goes directly to RESP next cycle
//   with rsp_z=0, rsp_err=0; no CLEAR/RUN, mul_en never asserted; latency 1 cycle.
//  DSC_EARLY_TERM_EN undefined: zero operands take the full RUN_CYCLES sequence (result still 0).
// STRUCTURE
//  Shared package dsc_pkg: SNG_WIDTH default, state encoding constants (IDLE/CLEAR/RUN/CAPTURE/RESP),
//   RUN_CYCLES derivation. Run counter instanced from the existing codebase `counter` module
//   (WIDTH=3*SNG_WIDTH, en=mul_en, its overflow marks end of RUN); FSM and latches in-module.
// TESTING
//  a=15,b=15,c=15, rsp_ready=1 -> rsp_z=3375, rsp_err=0, rsp_valid at T0+4099, mul_en high 4096 cycles.
//  a=8,b=4,c=2 -> rsp_z=64; a=1,b=1,c=1 -> rsp_z=1; a=0,b=7,c=9 without macro -> rsp_z=0 after 4099.
//  rsp_ready low 20 cycles after rsp_valid -> rsp_z held, req_ready=0, mul_en=0; accept only after handshake.
//  rst low at RUN cycle 1000 -> next cycle IDLE, mul_en=0, rsp_valid=0, mul_clr=1 during reset; new op correct.
//  With DSC_EARLY_TERM_EN: a=0,b=5,c=5 -> rsp_valid at T0+1, rsp_z=0, mul_en never high.
//  Model tying mul_ov=0 -> rsp_err=1 on response; back-to-back 3 requests with req_valid held -> 3 correct rsp.

Source files
------------

// File: rtl/dsc_pkg.sv
// Shared definitions for the deterministic stochastic multiplier sequencer.
//  - SNG_WIDTH_DEF : default operand width
//  - ST_*          : FSM state encodings (IDLE/CLEAR/RUN/CAPTURE/RESP)
//  - run_cycles()  : enabled cycles per multiply, 2^(3*SNG_WIDTH)
package dsc_pkg;

    localparam int SNG_WIDTH_DEF = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    // One full period of the three cascaded SNG counters.
    function automatic int run_cycles(input int sng_width);
        return 2 ** (3 * sng_width);
    endfunction

endpackage

// File: rtl/dsc_mul_seq_counter.sv
// Module: counter
// Wrapping up-counter with a terminal-count strobe.
// Ports:
//  clk  in   clock, rising edge
//  rst  in   synchronous reset, active-low
//  clr  in   synchronous clear to zero (has priority over en)
//  en   in   count enable
//  tc   out  combinational: en is high and the count sits at TERM,
//            i.e. this is the last enabled cycle before the count wraps
module counter #(
    parameter int               WIDTH = 12,
    parameter logic [WIDTH-1:0] TERM  = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            // At TERM the count returns to zero, so it is already clean
            // for the next run even without a clear.
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + WIDTH'(1);
        end
    end

    assign tc = en && !clr && (cnt_q == TERM);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dsc_mul_seq.sv
// Module: dsc_mul_seq
// Sequencer for one 3-input deterministic stochastic multiplier datapath.
// Accepts an operand triple, latches it onto the datapath, clears the
// datapath, enables it for exactly 2^(3*SNG_WIDTH) cycles, captures the
// result counter and returns it on a valid/ready response port.
// Ports:
//  clk, rst                 clock (rising edge), synchronous active-low reset
//  req_valid/req_ready      request handshake (ready only in IDLE)
//  req_a/b/c                operands
//  mul_a/b/c                latched operands, held until next accept or reset
//  mul_clr                  datapath clear (CLEAR state, or while rst is low)
//  mul_en                   datapath enable (RUN state)
//  mul_z, mul_ov            datapath result counter / final SNG overflow
//  rsp_valid/rsp_ready      response handshake
//  rsp_z, rsp_err           product; error = overflow never seen during RUN
//  busy                     any state but IDLE
// Configuration macro: DSC_EARLY_TERM_EN -- when defined, a request with any
// zero operand skips CLEAR/RUN and responds with zero on the next cycle.
module dsc_mul_seq
    import dsc_pkg::*;
#(
    parameter int SNG_WIDTH = SNG_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [SNG_WIDTH-1:0]   req_a,
    input  logic [SNG_WIDTH-1:0]   req_b,
    input  logic [SNG_WIDTH-1:0]   req_c,
    output logic [SNG_WIDTH-1:0]   mul_a,
    output logic [SNG_WIDTH-1:0]   mul_b,
    output logic [SNG_WIDTH-1:0]   mul_c,
    output logic                   mul_clr,
    output logic                   mul_en,
    input  logic [3*SNG_WIDTH-1:0] mul_z,
    input  logic                   mul_ov,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [3*SNG_WIDTH-1:0] rsp_z,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam int Z_W        = 3 * SNG_WIDTH;
    localparam int RUN_CYCLES = run_cycles(SNG_WIDTH);

    logic [2:0]           state_q,   state_d;
    logic [SNG_WIDTH-1:0] a_q,       a_d;
    logic [SNG_WIDTH-1:0] b_q,       b_d;
    logic [SNG_WIDTH-1:0] c_q,       c_d;
    logic [Z_W-1:0]       rsp_z_q,   rsp_z_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 ov_seen_q, ov_seen_d;
    logic                 run_done;
    logic                 accept;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign mul_en    = (state_q == ST_RUN);
    // Held high during reset so the datapath counters start from zero.
    assign mul_clr   = !rst || (state_q == ST_CLEAR);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign mul_c     = c_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_err   = rsp_err_q;

    // Run counter: its terminal count marks the last enabled cycle.
    counter #(
        .WIDTH (Z_W),
        .TERM  (Z_W'(RUN_CYCLES - 1))
    ) u_run_cnt (
        .clk (clk),
        .rst (rst),
        .clr (mul_clr),
        .en  (mul_en),
        .tc  (run_done)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        rsp_z_d   = rsp_z_q;
        rsp_err_d = rsp_err_q;
        ov_seen_d = ov_seen_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    c_d     = req_c;
                    state_d = ST_CLEAR;
`ifdef DSC_EARLY_TERM_EN
                    // A zero operand makes the product zero; skip the run.
                    if ((req_a == '0) || (req_b == '0) || (req_c == '0)) begin
                        state_d   = ST_RESP;
                        rsp_z_d   = '0;
                        rsp_err_d = 1'b0;
                    end
`endif
                end
            end
            ST_CLEAR: begin
                ov_seen_d = 1'b0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                ov_seen_d = ov_seen_q | mul_ov;
                if (run_done) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // The final-stage overflow must fire once per full period;
                // its absence means datapath and sequence disagree.
                rsp_z_d   = mul_z;
                rsp_err_d = ~ov_seen_q;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            rsp_z_q   <= '0;
            rsp_err_q <= 1'b0;
            ov_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            rsp_z_q   <= rsp_z_d;
            rsp_err_q <= rsp_err_d;
            ov_seen_q <= ov_seen_d;
        end
    end

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Testbench for dsc_mul_seq with a behavioural cascaded-SNG datapath model.
module tb_dsc_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_a = '0, req_b = '0, req_c = '0;
    logic [3:0]  mul_a, mul_b, mul_c;
    logic        mul_clr, mul_en;
    logic [11:0] mul_z;
    logic        mul_ov;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [11:0] rsp_z;
    logic        rsp_err;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dsc_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .mul_clr   (mul_clr),
        .mul_en    (mul_en),
        .mul_z     (mul_z),
        .mul_ov    (mul_ov),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    // Datapath model: three cascaded 4-bit counters; the unary stream bit
    // is high when every counter is below its operand, so one full period
    // accumulates exactly a*b*c ones.
    logic [3:0]  c1 = '0, c2 = '0, c3 = '0;
    logic [11:0] dp_z = '0;
    logic        dp_bit;
    logic        tie_ov0 = 1'b0;

    assign dp_bit = (c1 < mul_a) && (c2 < mul_b) && (c3 < mul_c);
    assign mul_z  = dp_z;
    assign mul_ov = mul_en && !tie_ov0 && (&c1) && (&c2) && (&c3);

    always @(posedge clk) begin
        if (mul_clr) begin
            c1 <= '0; c2 <= '0; c3 <= '0; dp_z <= '0;
        end else if (mul_en) begin
            dp_z <= dp_z + {11'b0, dp_bit};
            c1   <= c1 + 4'd1;
            if (&c1) c2 <= c2 + 4'd1;
            if ((&c1) && (&c2)) c3 <= c3 + 4'd1;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus: issue one request and wait (bounded) for rsp_valid.
    // Returns in the first RESP cycle, #1 after the edge. lat is the number
    // of edges from accept to rsp_valid (-1 on timeout).
    task automatic do_op(input logic [3:0] a, b, c,
                         output logic [11:0] z, output logic err,
                         output int lat, output int encnt);
        int guard;
        int n;
        lat = -1; encnt = 0; guard = 0;
        while (!req_ready && guard < 10000) begin
            @(posedge clk); #1; guard++;
        end
        req_a = a; req_b = b; req_c = c; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 6000) begin
            if (mul_en) encnt++;
            @(posedge clk); #1;
            n++;
        end
        if (rsp_valid) lat = n;
        z = rsp_z; err = rsp_err;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (mul_clr !== 1'b1) begin n_fail++; $display("FAIL reset_clr: got %0b expected 1", mul_clr); end
        n_chk++; if (mul_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %0b expected 0", mul_en); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_chk++; if (mul_a !== 4'd0 || mul_b !== 4'd0 || mul_c !== 4'd0) begin n_fail++; $display("FAIL reset_ops: got %0d/%0d/%0d expected 0/0/0", mul_a, mul_b, mul_c); end
        n_chk++; if (rsp_z !== 12'd0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got z=%0d err=%0b expected 0/0", rsp_z, rsp_err); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (mul_clr !== 1'b0) begin n_fail++; $display("FAIL post_reset_clr: got %0b expected 0", mul_clr); end
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %0b expected 1", req_ready); end
    endtask

    task automatic test_full_scale();
        logic [11:0] z; logic err; int lat, encnt;
        rsp_ready = 1'b1;
        do_op(4'd15, 4'd15, 4'd15, z, err, lat, encnt);
        n_chk++; if (z !== 12'd3375) begin n_fail++; $display("FAIL full_z: got %0d expected 3375", z); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL full_err: got %0b expected 0", err); end
        n_chk++; if (lat !== 4099) begin n_fail++; $display("FAIL full_latency: got %0d expected 4099", lat); end
        n_chk++; if (encnt !== 4096) begin n_fail++; $display("FAIL full_en_cycles: got %0d expected 4096", encnt); end
        @(posedge clk); #1;
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL full_resp_one_cycle: got %0b expected 0", rsp_valid); end
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL full_back_idle: got %0b expected 1", req_ready); end
        n_chk++; if (mul_a !== 4'd15 || mul_c !== 4'd15) begin n_fail++; $display("FAIL full_ops_held: got %0d/%0d expected 15/15", mul_a, mul_c); end
    endtask

    task automatic test_products();
        logic [3:0]  ta [2]; logic [3:0] tb_ [2]; logic [3:0] tc [2];
        logic [11:0] te [2];
        logic [11:0] z; logic err; int lat, encnt;
        ta[0] = 4'd8; tb_[0] = 4'd4; tc[0] = 4'd2; te[0] = 12'd64;
        ta[1] = 4'd1; tb_[1] = 4'd1; tc[1] = 4'd1; te[1] = 12'd1;
        for (int k = 0; k < 2; k++) begin
            do_op(ta[k], tb_[k], tc[k], z, err, lat, encnt);
            n_chk++; if (z !== te[k]) begin n_fail++; $display("FAIL product_%0d_z: got %0d expected %0d", k, z, te[k]); end
            n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL product_%0d_err: got %0b expected 0", k, err); end
            n_chk++; if (lat !== 4099) begin n_fail++; $display("FAIL product_%0d_latency: got %0d expected 4099", k, lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_operand();
        logic [11:0] z; logic err; int lat, encnt;
`ifdef DSC_EARLY_TERM_EN
        do_op(4'd0, 4'd5, 4'd5, z, err, lat, encnt);
        n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL early_latency: got %0d expected 1", lat); end
        n_chk++; if (encnt !== 0) begin n_fail++; $display("FAIL early_en_cycles: got %0d expected 0", encnt); end
`else
        do_op(4'd0, 4'd7, 4'd9, z, err, lat, encnt);
        n_chk++; if (lat !== 4099) begin n_fail++; $display("FAIL zero_latency: got %0d expected 4099", lat); end
        n_chk++; if (encnt !== 4096) begin n_fail++; $display("FAIL zero_en_cycles: got %0d expected 4096", encnt); end
`endif
        n_chk++; if (z !== 12'd0) begin n_fail++; $display("FAIL zero_z: got %0d expected 0", z); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL zero_err: got %0b expected 0", err); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        logic [11:0] z; logic err; int lat, encnt;
        rsp_ready = 1'b0;
        do_op(4'd2, 4'd3, 4'd4, z, err, lat, encnt);
        n_chk++; if (z !== 12'd24) begin n_fail++; $display("FAIL stall_z: got %0d expected 24", z); end
        // A competing request must not be taken while the response waits.
        req_a = 4'd9; req_b = 4'd9; req_c = 4'd9; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n_chk++; if (rsp_valid !== 1'b1 || rsp_z !== 12'd24) begin n_fail++; $display("FAIL stall_hold_%0d: got v=%0b z=%0d expected 1/24", i, rsp_valid, rsp_z); end
            n_chk++; if (req_ready !== 1'b0 || mul_en !== 1'b0 || mul_a !== 4'd2) begin n_fail++; $display("FAIL stall_idle_%0d: got rdy=%0b en=%0b a=%0d expected 0/0/2", i, req_ready, mul_en, mul_a); end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got v=%0b rdy=%0b expected 0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_midrun_reset();
        logic [11:0] z; logic err; int lat, encnt;
        req_a = 4'd7; req_b = 4'd7; req_c = 4'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (1001) @(posedge clk);
        #1;
        n_chk++; if (mul_en !== 1'b1) begin n_fail++; $display("FAIL midrun_running: got %0b expected 1", mul_en); end
        rst = 1'b0;
        #1;
        n_chk++; if (mul_clr !== 1'b1) begin n_fail++; $display("FAIL midrun_clr_in_reset: got %0b expected 1", mul_clr); end
        @(posedge clk); #1;
        n_chk++; if (busy !== 1'b0 || mul_en !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_abort: got busy=%0b en=%0b v=%0b expected 0/0/0", busy, mul_en, rsp_valid); end
        n_chk++; if (mul_a !== 4'd0) begin n_fail++; $display("FAIL midrun_ops_cleared: got %0d expected 0", mul_a); end
        rst = 1'b1;
        @(posedge clk); #1;
        do_op(4'd3, 4'd5, 4'd7, z, err, lat, encnt);
        n_chk++; if (z !== 12'd105 || err !== 1'b0) begin n_fail++; $display("FAIL midrun_next_op: got z=%0d err=%0b expected 105/0", z, err); end
        n_chk++; if (lat !== 4099) begin n_fail++; $display("FAIL midrun_next_latency: got %0d expected 4099", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_no_overflow();
        logic [11:0] z; logic err; int lat, encnt;
        tie_ov0 = 1'b1;
        do_op(4'd3, 4'd3, 4'd3, z, err, lat, encnt);
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL no_ov_err: got %0b expected 1", err); end
        n_chk++; if (z !== 12'd27) begin n_fail++; $display("FAIL no_ov_z: got %0d expected 27", z); end
        tie_ov0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  oa [3]; logic [3:0] ob [3]; logic [3:0] oc [3];
        logic [11:0] oe [3];
        int n;
        oa[0] = 4'd8; ob[0] = 4'd4; oc[0] = 4'd2; oe[0] = 12'd64;
        oa[1] = 4'd1; ob[1] = 4'd1; oc[1] = 4'd1; oe[1] = 12'd1;
        oa[2] = 4'd5; ob[2] = 4'd6; oc[2] = 4'd7; oe[2] = 12'd210;
        rsp_ready = 1'b1;
        req_a = oa[0]; req_b = ob[0]; req_c = oc[0]; req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_%0d_ready: got %0b expected 1", k, req_ready); end
            @(posedge clk); #1;
            n_chk++; if (busy !== 1'b1 || mul_a !== oa[k] || mul_c !== oc[k]) begin n_fail++; $display("FAIL b2b_%0d_accept: got busy=%0b a=%0d c=%0d expected 1/%0d/%0d", k, busy, mul_a, mul_c, oa[k], oc[k]); end
            if (k < 2) begin
                req_a = oa[k+1]; req_b = ob[k+1]; req_c = oc[k+1];
            end else begin
                req_valid = 1'b0;
            end
            n = 0;
            while (!rsp_valid && n < 6000) begin
                @(posedge clk); #1; n++;
            end
            n_chk++; if (rsp_valid !== 1'b1 || rsp_z !== oe[k] || rsp_err !== 1'b0) begin n_fail++; $display("FAIL b2b_%0d_rsp: got v=%0b z=%0d err=%0b expected 1/%0d/0", k, rsp_valid, rsp_z, rsp_err, oe[k]); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_products();
        test_zero_operand();
        test_stall();
        test_midrun_reset();
        test_no_overflow();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
